lstm_seq_ctrl: RTL and testbench

LSTM_SEQ_CTRL -- requirements
Module: lstm_seq_ctrl

---
 rtl/lstm_pkg.sv | 16 +
 rtl/ready_collect.sv | 26 ++
 rtl/lstm_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_lstm_seq_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - shared constants and state encoding for the LSTM step sequencer
package lstm_pkg;

    localparam int STEP_BITWIDTH_DEF = 16;
    localparam int N_GATES_DEF       = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_X = 3'd1,
        ST_GATES  = 3'd2,
        ST_ELEM   = 3'd3,
        ST_COMMIT = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/ready_collect.sv
// rtl/ready_collect.sv - sticky per-gate ready collector with combinational all-ready
module ready_collect #(
    parameter int N_GATES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic [N_GATES-1:0] ready,
    output logic               all_ready
);

    logic [N_GATES-1:0] r_flags;

    // Remember every gate that has reported ready since the last clear
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_flags <= '0;
        end else begin
            r_flags <= r_flags | ready;
        end
    end

    // Include this cycle's ready so the last gate is recognised the cycle it arrives
    assign all_ready = &(r_flags | ready);

endmodule

// File: rtl/lstm_seq_ctrl.sv
// rtl/lstm_seq_ctrl.sv - per-timestep LSTM sequencer (optional watchdog under SEQ_TIMEOUT_EN)
module lstm_seq_ctrl
    import lstm_pkg::*;
#(
    parameter int STEP_BITWIDTH  = STEP_BITWIDTH_DEF,
    parameter int N_GATES        = N_GATES_DEF,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [STEP_BITWIDTH-1:0] numSteps,
    input  logic [N_GATES-1:0]       gateReady,
    input  logic                     elemReady,
    output logic                     xLoad,
    output logic                     beginCalc,
    output logic                     elemStart,
    output logic                     hLatch,
    output logic [STEP_BITWIDTH-1:0] stepIdx,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam logic [STEP_BITWIDTH-1:0] STEP_ONE = {{(STEP_BITWIDTH-1){1'b0}}, 1'b1};

    seq_state_t               r_state;
    seq_state_t               w_state_next;
    logic                     r_first;
    logic [STEP_BITWIDTH-1:0] r_step_idx;
    logic [STEP_BITWIDTH-1:0] r_num_steps;
    logic [STEP_BITWIDTH-1:0] w_step_next;
    logic                     w_last_step;
    logic                     w_start_ok;
    logic                     w_collect_clear;
    logic [N_GATES-1:0]       w_collect_ready;
    logic                     w_all_ready;
    logic                     w_timeout;

    assign w_start_ok      = (r_state == ST_IDLE) && start;
    assign w_step_next     = r_step_idx + STEP_ONE;
    assign w_last_step     = (w_step_next == r_num_steps);
    // The beginCalc cycle clears the flags; ready seen in that cycle is dropped
    assign w_collect_clear = (r_state == ST_GATES) && r_first;
    assign w_collect_ready = gateReady & {N_GATES{(r_state == ST_GATES) && !r_first}};

    ready_collect #(
        .N_GATES (N_GATES)
    ) u_ready_collect (
        .clock     (clock),
        .reset     (reset),
        .clear     (w_collect_clear),
        .ready     (w_collect_ready),
        .all_ready (w_all_ready)
    );

`ifdef SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_error;

    assign w_timeout = ((r_state == ST_GATES) || (r_state == ST_ELEM)) && (r_tmo_cnt == TMO_LAST);

    // Watchdog: restarts on every state entry, counts only while waiting on gates or elementwise
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_GATES) || (r_state == ST_ELEM)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Sticky error: set by the watchdog, cleared by reset or the next accepted start
    always_ff @(posedge clock) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_timeout) begin
            r_error <= 1'b1;
        end else if (w_start_ok) begin
            r_error <= 1'b0;
        end
    end

    assign error = r_error;
`else
    assign w_timeout = 1'b0;
    assign error     = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; the first cycle of GATES and ELEM never advances
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (numSteps != '0) ? ST_LOAD_X : ST_DONE;
                end
            end
            ST_LOAD_X: w_state_next = ST_GATES;
            ST_GATES: begin
                if (!r_first && w_all_ready) begin
                    w_state_next = ST_ELEM;
                end
            end
            ST_ELEM: begin
                if (!r_first && elemReady) begin
                    w_state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: w_state_next = w_last_step ? ST_DONE : ST_LOAD_X;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_state_next = ST_IDLE;
        end
    end

    // Outputs decoded from the registered state and first-cycle marker
    always_comb begin
        xLoad     = (r_state == ST_LOAD_X);
        beginCalc = (r_state == ST_GATES) && r_first;
        elemStart = (r_state == ST_ELEM) && r_first;
        hLatch    = (r_state == ST_COMMIT);
        done      = (r_state == ST_DONE);
        busy      = (r_state != ST_IDLE);
        stepIdx   = r_step_idx;
    end

    // Step bookkeeping and first-cycle-of-state marker
    always_ff @(posedge clock) begin
        if (reset) begin
            r_first     <= 1'b0;
            r_step_idx  <= '0;
            r_num_steps <= '0;
        end else begin
            r_first <= (w_state_next != r_state);
            if (w_start_ok) begin
                r_step_idx  <= '0;
                r_num_steps <= numSteps;
            end else if ((r_state == ST_COMMIT) && !w_last_step) begin
                r_step_idx <= w_step_next;
            end
        end
    end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb/tb_lstm_seq_ctrl.sv - directed self-checking bench for lstm_seq_ctrl with hLatch/stepIdx scoreboard
module tb_lstm_seq_ctrl;

    localparam int W  = 16;
    localparam int NG = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  numSteps = '0;
    logic [NG-1:0] gateReady = '0;
    logic          elemReady = 1'b0;
    logic          xLoad, beginCalc, elemStart, hLatch, busy, done, error;
    logic [W-1:0]  stepIdx;

    lstm_seq_ctrl #(
        .STEP_BITWIDTH  (W),
        .N_GATES        (NG),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .numSteps  (numSteps),
        .gateReady (gateReady),
        .elemReady (elemReady),
        .xLoad     (xLoad),
        .beginCalc (beginCalc),
        .elemStart (elemStart),
        .hLatch    (hLatch),
        .stepIdx   (stepIdx),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int cnt_xload, cnt_begin, cnt_hl, cnt_done;
    int t_xload;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sb_exp;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse counting and hLatch scoreboard
    always @(negedge clock) begin
        if (!reset) begin
            if (xLoad) begin
                cnt_xload++;
                if (t_xload < 0) t_xload = cyc;
            end
            if (beginCalc) cnt_begin++;
            if (done) cnt_done++;
            if (hLatch) begin
                cnt_hl++;
                if (exp_q.size() == 0) begin
                    check("hlatch_unexpected", 32'(hLatch), 32'd0);
                end else begin
                    sb_exp = exp_q.pop_front();
                    check("hlatch_step_idx", 32'(stepIdx), 32'(sb_exp));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_counts();
        cnt_xload = 0;
        cnt_begin = 0;
        cnt_hl    = 0;
        cnt_done  = 0;
        t_xload   = -1;
    endtask

    task automatic wait_begin(input string tag);
        int n = 0;
        while (!beginCalc && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(beginCalc), 32'd1);
    endtask

    // One full step: gate k pulses d[k] cycles after beginCalc, elemReady one cycle after elemStart
    task automatic run_step(input int d0, input int d1, input int d2, input int d3);
        int d[4];
        int mx;
        d  = '{d0, d1, d2, d3};
        mx = 0;
        for (int i = 0; i < 4; i++) if (d[i] > mx) mx = d[i];
        wait_begin("begin_calc_seen");
        for (int k = 1; k <= mx; k++) begin
            tick();
            gateReady = '0;
            for (int i = 0; i < 4; i++) if (d[i] == k) gateReady[i] = 1'b1;
            check("elem_not_early", 32'(elemStart), 32'd0);
        end
        tick();
        gateReady = '0;
        check("elem_start_latency", 32'(elemStart), 32'd1);
        tick();
        elemReady = 1'b1;
        check("elem_start_one_cycle", 32'(elemStart), 32'd0);
        tick();
        elemReady = 1'b0;
        check("hlatch_in_commit", 32'(hLatch), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_xload"}, 32'(xLoad), 32'd0);
        check({tag, "_begin"}, 32'(beginCalc), 32'd0);
        check({tag, "_elem"},  32'(elemStart), 32'd0);
        check({tag, "_hlat"},  32'(hLatch), 32'd0);
        check({tag, "_err"},   32'(error), 32'd0);
        check({tag, "_step"},  32'(stepIdx), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_counts();

        // Reset state
        repeat (3) tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        // Three steps, all ready one cycle after beginCalc
        clear_counts();
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd2);
        numSteps = 16'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("t1_xload", 32'(xLoad), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        for (int s = 0; s < 3; s++) run_step(1, 1, 1, 1);
        check("t1_last_idx", 32'(stepIdx), 32'd2);
        tick();
        check("t1_done", 32'(done), 32'd1);
        check("t1_done_latency", 32'(cyc - t_xload), 32'd18);
        tick();
        check("t1_done_pulse", 32'(done), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_idx_hold", 32'(stepIdx), 32'd2);
        check("t1_n_xload", 32'(cnt_xload), 32'd3);
        check("t1_n_begin", 32'(cnt_begin), 32'd3);
        check("t1_n_hlatch", 32'(cnt_hl), 32'd3);
        check("t1_n_done", 32'(cnt_done), 32'd1);

        // Staggered gate readiness
        exp_q.push_back(16'd0);
        numSteps = 16'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        run_step(2, 5, 9, 3);
        tick();
        check("t2_done", 32'(done), 32'd1);
        tick();

        // Ready held through beginCalc then dropped must not advance
        exp_q.push_back(16'd0);
        numSteps = 16'd1;
        start    = 1'b1;
        tick();
        start     = 1'b0;
        gateReady = '1;
        tick();
        check("t3_begin", 32'(beginCalc), 32'd1);
        tick();
        gateReady = '0;
        for (int i = 0; i < 6; i++) begin
            check("t3_stay_gates", 32'(elemStart), 32'd0);
            check("t3_busy", 32'(busy), 32'd1);
            tick();
        end
        gateReady = '1;
        tick();
        gateReady = '0;
        check("t3_recover_elem", 32'(elemStart), 32'd1);
        tick();
        elemReady = 1'b1;
        tick();
        elemReady = 1'b0;
        check("t3_hlatch", 32'(hLatch), 32'd1);
        tick();
        check("t3_done", 32'(done), 32'd1);
        tick();

        // numSteps = 0 goes straight to DONE
        clear_counts();
        numSteps = 16'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("t4_zero_done", 32'(done), 32'd1);
        check("t4_zero_nobegin", 32'(beginCalc), 32'd0);
        check("t4_zero_noxload", 32'(xLoad), 32'd0);
        tick();
        check("t4_zero_idle", 32'(busy), 32'd0);
        check("t4_zero_begin_cnt", 32'(cnt_begin), 32'd0);

        // start and numSteps changes during a run are ignored
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd1);
        numSteps = 16'd2;
        start    = 1'b1;
        tick();
        numSteps = 16'd7;
        run_step(1, 1, 1, 1);
        run_step(1, 2, 1, 2);
        start = 1'b0;
        tick();
        check("t4_busy_done", 32'(done), 32'd1);
        check("t4_busy_idx", 32'(stepIdx), 32'd1);
        tick();
        check("t4_busy_idle", 32'(busy), 32'd0);
        check("t4_busy_xloads", 32'(cnt_xload), 32'd2);

        // Reset in ELEM of step 1, then a clean run
        exp_q.push_back(16'd0);
        numSteps = 16'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        run_step(1, 1, 1, 1);
        wait_begin("t5_begin1");
        tick();
        gateReady = '1;
        tick();
        gateReady = '0;
        check("t5_in_elem", 32'(elemStart), 32'd1);
        check("t5_idx1", 32'(stepIdx), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("t5_reset");
        tick();
        check("t5_stay_idle", 32'(busy), 32'd0);
        exp_q.push_back(16'd0);
        numSteps = 16'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        run_step(3, 1, 2, 1);
        tick();
        check("t5_done", 32'(done), 32'd1);
        tick();

`ifdef SEQ_TIMEOUT_EN
        // Gate 2 never ready: watchdog aborts without done
        clear_counts();
        numSteps = 16'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_begin("t6_begin");
        gateReady = 4'b1011;
        repeat (15) tick();
        check("t6_pre_busy", 32'(busy), 32'd1);
        check("t6_pre_err", 32'(error), 32'd0);
        tick();
        gateReady = '0;
        check("t6_err", 32'(error), 32'd1);
        check("t6_idle", 32'(busy), 32'd0);
        check("t6_no_done", 32'(cnt_done), 32'd0);
        tick();
        check("t6_err_sticky", 32'(error), 32'd1);
        numSteps = 16'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("t6_err_clear", 32'(error), 32'd0);
        tick();
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
